axis_to_aximm_writer: RTL and testbench
=======================================

// Module: axis_to_aximm_writer
// PURPOSE
// - Drains AXI-Stream packets from the upstream axis_fifo master port into memory as AXI4 INCR write bursts.
// - Collects up to BURST_LEN beats in a local buffer, then issues AW with the exact length and replays the buffer on W.
// - Packet boundary is s_axis_tlast. One packet per start command; reports done, beat count and write-response errors.
// PARAMETERS
// - DATA_WIDTH  32  stream/AXI data width in bits; power of 2, >= 8
// - ADDR_WIDTH  32  AXI address width in bits
// - BURST_LEN   16  max beats per burst; power of 2, 1..256; BURST_LEN*DATA_WIDTH/8 <= 4096
// PORTS
// - ACLK           in   1        clock, all logic on rising edge
// - ARESET         in   1        asynchronous, active-high reset
// - start          in   1        1-cycle pulse: begin a packet transfer (ignored unless busy==0)
// - base_addr      in   ADDR_W   first write address, latched on start; aligned to BURST_LEN*DATA_WIDTH/8
// - busy           out  1        high from the cycle after start until done
// - done           out  1        1-cycle pulse after final B response of the packet
// - beat_count     out  32       beats accepted for current/last packet; cleared on start
// - error          out  1        sticky: any BRESP != 2'b00 since last start
// - s_axis_tdata   in   DATA_W   stream data (from axis_fifo m_axis_*)
// - s_axis_tlast   in   1        last beat of packet
// - s_axis_tvalid  in   1        stream valid
// - s_axis_tready  out  1        stream ready
// - m_axi_awaddr   out  ADDR_W   burst start address
// - m_axi_awlen    out  8        beats-1
// - m_axi_awsize   out  3        $clog2(DATA_WIDTH/8), constant
// - m_axi_awburst  out  2        2'b01 (INCR), constant
// - m_axi_awvalid  out  1 / m_axi_awready in 1   AW handshake
// - m_axi_wdata    out  DATA_W   write data from buffer
// - m_axi_wstrb    out  DATA_W/8 all ones
// - m_axi_wlast    out  1        high on beat awlen
// - m_axi_wvalid   out  1 / m_axi_wready  in 1   W handshake
// - m_axi_bresp    in   2        write response
// - m_axi_bvalid   in   1 / m_axi_bready  out 1  B handshake
// BEHAVIOUR
// - Reset (async assert): state IDLE; busy, done, error, s_axis_tready, awvalid, wvalid, wlast, bready = 0; beat_count, awaddr, awlen = 0.
// - FSM IDLE->FILL->AW->W->B->(FILL|IDLE). One outstanding burst; no AW/W overlap.
// - IDLE: start -> latch base_addr, clear beat_count/error, busy=1, go FILL next cycle. start while busy ignored.
// - FILL: tready=1 while fill_cnt<BURST_LEN. Each accepted beat -> buffer[fill_cnt], beat_count+1.
//   Go AW when the accepted beat is tlast or fill_cnt reaches BURST_LEN; tready=0 from next cycle. last_burst flag = tlast seen.
// - AW: awvalid=1, awaddr=cur_addr, awlen=fill_cnt-1, held stable until awready; then W.
// - W: beats from buffer index 0.., wvalid=1, data stable until wready; wlast on index awlen; after last handshake -> B.
// - B: bready=1; on bvalid: bresp!=0 sets error; cur_addr += (awlen+1)*DATA_WIDTH/8 (mod 2^ADDR_WIDTH);
//   last_burst ? (done=1, busy=0, IDLE) : FILL.
// - Minimum latency tlast accept -> awvalid: 1 cycle. Burst never crosses 4 KB given aligned base_addr.
// - Packet of exactly k*BURST_LEN beats: final burst full, no empty burst issued.
// - Stream stalls (tvalid=0) in FILL: wait, no timeout. Buffer write and W read never in same state.
// - ARESET mid-transfer: FSM to IDLE immediately; in-flight AXI transaction abandoned (system-wide reset).
// CONFIGURATION
// - AXIS2MM_ERR_ABORT_EN defined: on bresp!=0, stop issuing bursts; enter DRAIN: tready=1, discard beats
//   (beat_count still counts) until tlast accepted, then done pulse, IDLE. If error burst was last_burst, done immediately.
// - Undefined: error is only recorded (sticky); transfer continues to packet end normally.
// TESTING
// - start base=0x1000, 5-beat packet 0..4 -> one AW addr 0x1000 len 4; W 0..4, wlast on 5th; done; beat_count=5.
// - 40-beat packet, BURST_LEN=16 -> AWs 0x1000/len15, 0x1040/len15, 0x1080/len7; error=0; done once.
// - 32-beat packet -> exactly two AWs len15, no third burst; done after second B.
// - Random awready/wready/bvalid delays 0-5 cycles, tvalid gaps -> data/addr match, AW/W payload stable under stall.
// - bresp=2'b10 on first of 3 bursts: ABORT_EN -> no further AW, remaining beats drained, error=1, done; else 3 bursts, error=1.
// - ARESET asserted during W state -> all outputs 0 same cycle; new start afterwards completes normally.

Source files
------------

// File: rtl/axis_to_aximm_writer.sv
// axis_to_aximm_writer: buffers up to BURST_LEN stream beats, then writes them as one AXI4 INCR burst.
// Define AXIS2MM_ERR_ABORT_EN to stop bursting after an error response and drain the rest of the packet.
module axis_to_aximm_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             beat_count,
  output logic                    error,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int CW = $clog2(BURST_LEN) + 1;
  typedef enum logic [2:0] {IDLE, FILL, AW, W, B, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, awaddr_q, awaddr_d;
  logic [7:0] awlen_q, awlen_d;
  logic [31:0] beat_count_q, beat_count_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];
  logic s_fire, b_err;
  assign s_axis_tready = (state_q == FILL && fill_cnt_q < CW'(BURST_LEN)) || state_q == DRAIN;
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign b_err = m_axi_bresp != 2'b00;
  assign m_axi_awvalid = state_q == AW;
  assign m_axi_wvalid = state_q == W;
  assign m_axi_bready = state_q == B;
  assign m_axi_wlast = state_q == W && 8'(rd_idx_q) == awlen_q;
  assign m_axi_wdata = mem_q[rd_idx_q];
  assign m_axi_wstrb = '1;
  assign m_axi_awsize = 3'($clog2(BYTES));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awaddr = awaddr_q;
  assign m_axi_awlen = awlen_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign beat_count = beat_count_q;
  always_comb begin
    state_d = state_q;
    fill_cnt_d = fill_cnt_q;
    rd_idx_d = rd_idx_q;
    cur_addr_d = cur_addr_q;
    awaddr_d = awaddr_q;
    awlen_d = awlen_q;
    beat_count_d = beat_count_q;
    busy_d = busy_q;
    done_d = 1'b0;
    error_d = error_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        busy_d = 1'b1;
        cur_addr_d = base_addr;
        beat_count_d = '0;
        error_d = 1'b0;
        fill_cnt_d = '0;
      end
      FILL: if (s_fire) begin
        fill_cnt_d = fill_cnt_q + CW'(1);
        beat_count_d = beat_count_q + 32'd1;
        if (s_axis_tlast || fill_cnt_d == CW'(BURST_LEN)) begin
          state_d = AW;
          last_d = s_axis_tlast;
          awaddr_d = cur_addr_q;
          awlen_d = 8'(fill_cnt_q);
        end
      end
      AW: if (m_axi_awready) begin
        state_d = W;
        rd_idx_d = '0;
      end
      W: if (m_axi_wready) begin
        if (m_axi_wlast) state_d = B;
        else rd_idx_d = rd_idx_q + IW'(1);
      end
      B: if (m_axi_bvalid) begin
        error_d = error_q | b_err;
        cur_addr_d = cur_addr_q + ADDR_WIDTH'((32'(awlen_q) + 32'd1) * 32'(BYTES));
        fill_cnt_d = '0;
        state_d = last_q ? IDLE : FILL;
        done_d = last_q;
        busy_d = !last_q;
`ifdef AXIS2MM_ERR_ABORT_EN
        if (b_err && !last_q) state_d = DRAIN;
`endif
      end
      DRAIN: if (s_fire) begin
        beat_count_d = beat_count_q + 32'd1;
        if (s_axis_tlast) begin
          state_d = IDLE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      fill_cnt_q <= '0;
      rd_idx_q <= '0;
      cur_addr_q <= '0;
      awaddr_q <= '0;
      awlen_q <= '0;
      beat_count_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_idx_q <= rd_idx_d;
      cur_addr_q <= cur_addr_d;
      awaddr_q <= awaddr_d;
      awlen_q <= awlen_d;
      beat_count_q <= beat_count_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      last_q <= last_d;
    end
  end
  // Buffer holds data only, so it needs no reset.
  always_ff @(posedge ACLK) begin
    if (state_q == FILL && s_fire) mem_q[fill_cnt_q[IW-1:0]] <= s_axis_tdata;
  end
endmodule

// File: tb/tb_axis_to_aximm_writer.sv
// tb_axis_to_aximm_writer: random stream/AXI-slave stimulus checked against a packet-level burst model.
module tb_axis_to_aximm_writer;
  logic        ACLK = 0, ARESET = 0, start = 0;
  logic [31:0] base_addr = 0;
  logic        busy, done, error;
  logic [31:0] beat_count;
  logic [31:0] s_axis_tdata = 0;
  logic        s_axis_tlast = 0, s_axis_tvalid = 0, s_axis_tready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready = 0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 0;
  logic [1:0]  m_axi_bresp = 0;
  logic        m_axi_bvalid = 0, m_axi_bready;

  axis_to_aximm_writer dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .beat_count(beat_count), .error(error),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, errors = 0;
  logic [31:0] pkt[$];
  logic [39:0] exp_aw[$], obs_aw[$];
  logic [32:0] exp_w[$];
  logic [1:0]  plan[$];
  logic        exp_err;
  int          pending_b = 0, b_idx = 0, done_cnt = 0;
  logic        b_hs = 0, hold_w = 0;
  logic [31:0] done_bc = 0;
  logic        done_err = 0;
  logic        prev_aw_stall = 0, prev_w_stall = 0;
  logic [39:0] prev_aw = 0;
  logic [32:0] prev_w = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected bursts: 16-beat chunks at 64-byte strides, truncated after an error burst when aborting.
  task automatic build_model(input logic [31:0] base, input int n, input int err_b);
    int nb;
    nb = (n + 15) / 16;
    exp_aw.delete(); exp_w.delete(); obs_aw.delete(); plan.delete();
    b_idx = 0;
    exp_err = 0;
    for (int b = 0; b < nb; b++) begin
      int len;
      len = ((n - 16 * b) > 16 ? 16 : n - 16 * b) - 1;
      plan.push_back(b == err_b ? 2'b10 : 2'b00);
`ifdef AXIS2MM_ERR_ABORT_EN
      if (err_b >= 0 && b > err_b) continue;
`endif
      exp_aw.push_back({base + 32'(b * 64), 8'(len)});
      for (int j = 0; j <= len; j++) exp_w.push_back({pkt[16 * b + j], j == len});
      if (b == err_b) exp_err = 1;
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_aw_stall = 0;
      prev_w_stall = 0;
    end else begin
      chk("overlap", {m_axi_awvalid && m_axi_wvalid, s_axis_tready && (m_axi_awvalid || m_axi_wvalid)}, 0);
      if (prev_aw_stall) chk("aw_stable", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, prev_aw});
      if (prev_w_stall) chk("w_stable", {m_axi_wvalid, m_axi_wdata, m_axi_wlast}, {1'b1, prev_w});
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_expected", exp_aw.size() > 0, 1);
        chk("aw_const", {m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {3'd2, 2'b01, 4'hf});
        if (exp_aw.size() > 0) chk("aw", {m_axi_awaddr, m_axi_awlen}, exp_aw.pop_front());
        obs_aw.push_back({m_axi_awaddr, m_axi_awlen});
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) chk("w", {m_axi_wdata, m_axi_wlast}, exp_w.pop_front());
        if (m_axi_wlast) pending_b++;
      end
      if (m_axi_bvalid && m_axi_bready) b_hs = 1;
      if (done) begin
        done_cnt++;
        done_bc = beat_count;
        done_err = error;
        chk("done_busy", busy, 0);
      end
      prev_aw_stall = m_axi_awvalid && !m_axi_awready;
      prev_aw = {m_axi_awaddr, m_axi_awlen};
      prev_w_stall = m_axi_wvalid && !m_axi_wready;
      prev_w = {m_axi_wdata, m_axi_wlast};
    end
  end

  initial forever begin
    @(posedge ACLK); #1;
    m_axi_awready = $urandom_range(0, 2) == 0;
    m_axi_wready = !hold_w && $urandom_range(0, 1) == 0;
    if (ARESET) m_axi_bvalid = 0;
    else if (b_hs) begin
      m_axi_bvalid = 0;
      b_hs = 0;
    end else if (!m_axi_bvalid && pending_b > 0 && $urandom_range(0, 2) == 0) begin
      m_axi_bvalid = 1;
      m_axi_bresp = b_idx < plan.size() ? plan[b_idx] : 2'b00;
      b_idx++;
      pending_b--;
    end
  end

  task automatic stream(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      int cnt;
      cnt = 0;
      repeat ($urandom_range(0, 3)) begin @(posedge ACLK); #1; end
      if (poke && i == 1) begin
        start = 1; base_addr = 32'hdead0000;
        @(posedge ACLK); #1;
        start = 0;
      end
      s_axis_tvalid = 1; s_axis_tdata = pkt[i]; s_axis_tlast = i == n - 1;
      do begin @(negedge ACLK); cnt++; end while (!s_axis_tready && cnt < 3000);
      if (cnt >= 3000) chk("tready_timeout", cnt, 0);
      @(posedge ACLK); #1;
      s_axis_tvalid = 0; s_axis_tlast = 0;
    end
  endtask

  task automatic run_packet(input logic [31:0] base, input int n, input int err_b, input bit poke);
    int d0, cnt;
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back($urandom);
    build_model(base, n, err_b);
    start = 1; base_addr = base;
    @(posedge ACLK); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    d0 = done_cnt;
    stream(n, poke);
    cnt = 0;
    do begin @(negedge ACLK); cnt++; end while (done_cnt == d0 && cnt < 5000);
    if (cnt >= 5000) chk("done_timeout", done_cnt, d0 + 1);
    repeat (10) @(posedge ACLK);
    #1;
    chk("done_once", done_cnt, d0 + 1);
    chk("beat_count", done_bc, n);
    chk("error", done_err, exp_err);
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #3 ARESET = 1;
    #2;
    chk("rst_outs", {busy, done, error, s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 0);
    chk("rst_regs", {beat_count, m_axi_awaddr}, 0);
    chk("rst_awlen", m_axi_awlen, 0);
    chk("consts", {m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {3'd2, 2'b01, 4'hf});
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    @(posedge ACLK); #1;

    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(32'(i));
    build_model(32'h1000, 5, -1);
    chk("model_w4", exp_w[4], {32'd4, 1'b1});
    start = 1; base_addr = 32'h1000;
    @(posedge ACLK); #1;
    start = 0;
    stream(5, 0);
    cnt = 0;
    do begin @(negedge ACLK); cnt++; end while (!done && cnt < 5000);
    chk("p1_done", done, 1);
    chk("p1_bc", beat_count, 5);
    chk("p1_naw", obs_aw.size(), 1);
    chk("p1_aw", obs_aw[0], {32'h1000, 8'd4});
    @(posedge ACLK); #1;

    run_packet(32'h1000, 40, -1, 1);
    chk("p2_naw", obs_aw.size(), 3);
    chk("p2_aw0", obs_aw[0], {32'h1000, 8'd15});
    chk("p2_aw1", obs_aw[1], {32'h1040, 8'd15});
    chk("p2_aw2", obs_aw[2], {32'h1080, 8'd7});
    chk("p2_err", done_err, 0);

    run_packet(32'h1000, 32, -1, 0);
    chk("p3_naw", obs_aw.size(), 2);
    chk("p3_aw1", obs_aw[1], {32'h1040, 8'd15});

    run_packet(32'h4000, 40, 0, 0);
`ifdef AXIS2MM_ERR_ABORT_EN
    chk("p4_naw", obs_aw.size(), 1);
`else
    chk("p4_naw", obs_aw.size(), 3);
`endif
    chk("p4_err", done_err, 1);
    chk("p4_bc", done_bc, 40);

    run_packet(32'h5000, 7, -1, 0);
    chk("p5_err_cleared", done_err, 0);

    run_packet(32'hffffffc0, 20, -1, 0);
    chk("p6_wrap", obs_aw[1], {32'h0, 8'd3});

    for (int k = 0; k < 12; k++) begin
      int n, e;
      n = $urandom_range(1, 50);
      e = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, (n - 1) / 16)) : -1;
      run_packet($urandom & 32'hffffffc0, n, e, 0);
    end

    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back($urandom);
    build_model(32'h2000, 5, -1);
    hold_w = 1;
    start = 1; base_addr = 32'h2000;
    @(posedge ACLK); #1;
    start = 0;
    stream(5, 0);
    cnt = 0;
    do begin @(negedge ACLK); cnt++; end while (!m_axi_wvalid && cnt < 200);
    chk("reached_w", m_axi_wvalid, 1);
    #2 ARESET = 1;
    #1;
    chk("mid_rst_outs", {busy, done, error, s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 0);
    chk("mid_rst_regs", {beat_count, m_axi_awaddr, m_axi_awlen}, 0);
    exp_aw.delete(); exp_w.delete();
    pending_b = 0; b_hs = 0; hold_w = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;
    @(posedge ACLK); #1;
    run_packet(32'h3000, 9, -1, 0);
    chk("post_rst_aw", obs_aw[0], {32'h3000, 8'd8});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
